// File: rtl/fan_driver_pkg.sv
// fan_driver_pkg: shared types and helpers for the fan/heater actuator driver.
//   drv_state_e   - 3-bit FSM state encoding, visible on drv_state
//   PWM_W         - PWM counter / duty width
//   target_duty() - expands a 3-bit speed command to an 8-bit duty
package fan_driver_pkg;

  localparam int PWM_W = 8;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_SPINUP   = 3'd1,
    ST_RUN      = 3'd2,
    ST_COOLDOWN = 3'd3,
    ST_FAULT    = 3'd4
  } drv_state_e;

  // Bit replication spreads 0..7 evenly over 0..255 (7 -> 255 exactly).
  function automatic logic [PWM_W-1:0] target_duty(input logic [2:0] speed);
    return {speed, speed, speed[2:1]};
  endfunction

endpackage

// File: rtl/fan_driver_if.sv
// fan_driver_if: command/drive bundle between AC_control, fan_driver and
// the board-level fan/heater drivers.
//   master - command side: drives fan_speed, fan_heat, fan_tach; observes drive
//   slave  - fan_driver: consumes commands, produces PWM, duty, state, fault
interface fan_driver_if;
  import fan_driver_pkg::*;

  logic [2:0]       fan_speed;
  logic [7:0]       fan_heat;
  logic             fan_tach;
  logic             fan_pwm;
  logic             heat_pwm;
  logic [PWM_W-1:0] fan_duty;
  logic [2:0]       drv_state;
  logic             fault;

  modport master (
    output fan_speed, fan_heat, fan_tach,
    input  fan_pwm, heat_pwm, fan_duty, drv_state, fault
  );

  modport slave (
    input  fan_speed, fan_heat, fan_tach,
    output fan_pwm, heat_pwm, fan_duty, drv_state, fault
  );

endinterface

// File: rtl/fan_driver_pwm_gen.sv
// pwm_gen: 8-bit free-running PWM with duty latched at counter wrap.
//   clk, reset - clock, async active-low reset
//   en         - counter enable
//   clr        - synchronously zero the latched duty and the output
//   duty_i     - requested duty
//   duty_o     - duty currently applied (latched at cnt == 255)
//   pwm_o      - registered (cnt < applied duty); duty 255 -> 255/256 high
module pwm_gen import fan_driver_pkg::*; (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             clr,
  input  logic [PWM_W-1:0] duty_i,
  output logic [PWM_W-1:0] duty_o,
  output logic             pwm_o
);

  logic [PWM_W-1:0] cnt_q, cnt_d;
  logic [PWM_W-1:0] lat_q, lat_d;
  logic             pwm_q, pwm_d;

  always_comb begin
    cnt_d = en ? cnt_q + 1'b1 : cnt_q;
    lat_d = lat_q;
    if (clr)                   lat_d = '0;
    else if (en && &cnt_q)     lat_d = duty_i;
    pwm_d = clr ? 1'b0 : (cnt_q < lat_q);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
      lat_q <= '0;
      pwm_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      lat_q <= lat_d;
      pwm_q <= pwm_d;
    end
  end

  assign duty_o = lat_q;
  assign pwm_o  = pwm_q;

endmodule

// File: rtl/fan_driver.sv
// fan_driver: turns fan_speed/fan_heat commands into fan and heater PWM.
// Ramps fan duty, interlocks the heater on airflow, runs the fan on after
// heating, and faults on a stalled tach.
//   clk   - system clock
//   reset - async active-low reset
//   bus   - fan_driver_if.slave (commands in, PWM/duty/state/fault out)
module fan_driver import fan_driver_pkg::*; #(
  parameter int unsigned      RAMP_DIV       = 16,
  parameter logic [PWM_W-1:0] HEAT_MIN_DUTY  = 8'd64,
  parameter int unsigned      COOL_CYCLES    = 1024,
  parameter int unsigned      STALL_CYCLES   = 4096,
  parameter logic [PWM_W-1:0] STALL_MIN_DUTY = 8'd32
) (
  input logic          clk,
  input logic          reset,
  fan_driver_if.slave  bus
);

  localparam int PRE_W   = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
  localparam int COOL_W  = $clog2(COOL_CYCLES + 1);
  localparam int STALL_W = $clog2(STALL_CYCLES + 1);

  drv_state_e       state_q, state_d;
  logic [PWM_W-1:0] duty_q, duty_d;
  logic [PRE_W-1:0] pre_q, pre_d;
  logic [COOL_W-1:0]  cool_q, cool_d;
  logic [STALL_W-1:0] stall_q, stall_d;
  logic             heat_was_on_q, heat_was_on_d;
  logic             tach_meta_q, tach_meta_d;
  logic             tach_sync_q, tach_sync_d;
  logic             tach_prev_q, tach_prev_d;

  logic [PWM_W-1:0] target, goal, heat_req, heat_duty;
  logic [PWM_W-1:0] fan_applied, heat_applied_unused;
  logic             tick, speed_zero, runon_active, stall_hit, check_active;
  logic             tach_rise, pwm_en, pwm_clr;

  assign pwm_en = 1'b1;

  always_comb begin
    target       = target_duty(bus.fan_speed);
    speed_zero   = (bus.fan_speed == 3'd0);
    tick         = (pre_q == PRE_W'(RAMP_DIV - 1));
    pre_d        = tick ? '0 : pre_q + 1'b1;
    runon_active = heat_was_on_q && (cool_q != COOL_W'(COOL_CYCLES));
    stall_hit    = (stall_q == STALL_W'(STALL_CYCLES));

    tach_meta_d  = bus.fan_tach;
    tach_sync_d  = tach_meta_q;
    tach_prev_d  = tach_sync_q;
    tach_rise    = tach_sync_q && !tach_prev_q;

    check_active = (state_q inside {ST_SPINUP, ST_RUN, ST_COOLDOWN}) &&
                   (fan_applied >= STALL_MIN_DUTY);
    stall_d      = (check_active && !tach_rise) ? stall_q + 1'b1 : '0;

    state_d       = state_q;
    goal          = '0;
    heat_req      = '0;
    heat_duty     = '0;
    heat_was_on_d = heat_was_on_q;
    cool_d        = cool_q;

    // Priority in every active state: stall fault, then stop, then progress.
    unique case (state_q)
      ST_IDLE: begin
        if (!speed_zero) begin
          state_d       = ST_SPINUP;
          heat_was_on_d = 1'b0;
          cool_d        = '0;
        end
      end
      ST_SPINUP: begin
        goal = target;
        if (stall_hit) state_d = ST_FAULT;
        else if (speed_zero) begin
          state_d       = ST_COOLDOWN;
          heat_was_on_d = 1'b0;
          cool_d        = '0;
        end else if (duty_q == target) state_d = ST_RUN;
      end
      ST_RUN: begin
        goal     = target;
        heat_req = (duty_q >= HEAT_MIN_DUTY) ? bus.fan_heat : '0;
        // Heat is dropped on the stop cycle itself so a wrap latch there
        // cannot carry it into cooldown.
        heat_duty = speed_zero ? '0 : heat_req;
        if (stall_hit) state_d = ST_FAULT;
        else if (speed_zero) begin
          state_d       = ST_COOLDOWN;
          heat_was_on_d = (heat_req != '0);
          cool_d        = '0;
        end
      end
      ST_COOLDOWN: begin
        goal = runon_active ? HEAT_MIN_DUTY : '0;
        // Run-on time counts only once the fan has settled at the purge duty.
        if (runon_active && duty_q == HEAT_MIN_DUTY) cool_d = cool_q + 1'b1;
        if (stall_hit) state_d = ST_FAULT;
        else if (!speed_zero) begin
          state_d       = ST_SPINUP;
          heat_was_on_d = 1'b0;
          cool_d        = '0;
        end else if (duty_q == '0 && !runon_active) state_d = ST_IDLE;
      end
      ST_FAULT: begin
        if (speed_zero) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // Clearing on the transition edge zeroes duty and PWM the same cycle
    // fault asserts.
    pwm_clr = (state_d == ST_FAULT);

    duty_d = duty_q;
    if (pwm_clr)                     duty_d = '0;
    else if (tick && duty_q < goal)  duty_d = duty_q + 1'b1;
    else if (tick && duty_q > goal)  duty_d = duty_q - 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= ST_IDLE;
      duty_q        <= '0;
      pre_q         <= '0;
      cool_q        <= '0;
      stall_q       <= '0;
      heat_was_on_q <= 1'b0;
      tach_meta_q   <= 1'b0;
      tach_sync_q   <= 1'b0;
      tach_prev_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      duty_q        <= duty_d;
      pre_q         <= pre_d;
      cool_q        <= cool_d;
      stall_q       <= stall_d;
      heat_was_on_q <= heat_was_on_d;
      tach_meta_q   <= tach_meta_d;
      tach_sync_q   <= tach_sync_d;
      tach_prev_q   <= tach_prev_d;
    end
  end

  pwm_gen u_fan_pwm (
    .clk    (clk),
    .reset  (reset),
    .en     (pwm_en),
    .clr    (pwm_clr),
    .duty_i (duty_q),
    .duty_o (fan_applied),
    .pwm_o  (bus.fan_pwm)
  );

  pwm_gen u_heat_pwm (
    .clk    (clk),
    .reset  (reset),
    .en     (pwm_en),
    .clr    (pwm_clr),
    .duty_i (heat_duty),
    .duty_o (heat_applied_unused),
    .pwm_o  (bus.heat_pwm)
  );

  assign bus.fan_duty  = duty_q;
  assign bus.drv_state = state_q;
  assign bus.fault     = (state_q == ST_FAULT);

endmodule

// File: tb/tb_fan_driver.sv
// tb_fan_driver: directed self-checking bench for fan_driver with a short
// ramp (RAMP_DIV=2), short run-on (64) and stall limit (600). Tach toggles
// every 200 clocks while tach_en is set.
module tb_fan_driver;
  import fan_driver_pkg::*;

  logic clk     = 1'b0;
  logic reset   = 1'b1;
  logic tach_en = 1'b1;
  int   tests_run    = 0;
  int   tests_failed = 0;

  fan_driver_if u_if ();

  fan_driver #(
    .RAMP_DIV       (2),
    .HEAT_MIN_DUTY  (8'd64),
    .COOL_CYCLES    (64),
    .STALL_CYCLES   (600),
    .STALL_MIN_DUTY (8'd32)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (u_if.slave)
  );

  always #5 clk = ~clk;

  initial begin
    u_if.fan_tach = 1'b0;
    forever begin
      repeat (200) @(negedge clk);
      if (tach_en) u_if.fan_tach = ~u_if.fan_tach;
    end
  end

  task automatic test_reset();
    int bad;
    u_if.fan_speed = 3'd0;
    u_if.fan_heat  = 8'd0;
    #2 reset = 1'b0;
    #1;
    tests_run++;
    if ({u_if.fan_pwm, u_if.heat_pwm, u_if.fan_duty, u_if.drv_state, u_if.fault} !== 14'd0) begin
      tests_failed++;
      $display("FAIL reset_outputs: got %0h, expected 0",
               {u_if.fan_pwm, u_if.heat_pwm, u_if.fan_duty, u_if.drv_state, u_if.fault});
    end
    @(negedge clk) reset = 1'b1;
    bad = 0;
    repeat (1000) begin
      @(negedge clk);
      if ({u_if.fan_pwm, u_if.heat_pwm, u_if.fan_duty, u_if.drv_state, u_if.fault} !== 14'd0) bad++;
    end
    tests_run++;
    if (bad !== 0) begin
      tests_failed++;
      $display("FAIL idle_quiet: got %0d nonzero cycles, expected 0", bad);
    end
  endtask

  task automatic test_spinup();
    int n, hi;
    @(negedge clk) u_if.fan_speed = 3'd7;
    @(negedge clk);
    tests_run++;
    if (u_if.drv_state !== 3'd1) begin
      tests_failed++;
      $display("FAIL spinup_state: got %0d, expected 1", u_if.drv_state);
    end
    n = 1;
    while (u_if.fan_duty !== 8'd255 && n < 700) begin
      @(negedge clk);
      n++;
    end
    tests_run++;
    if (n < 509 || n > 513) begin
      tests_failed++;
      $display("FAIL ramp_time: got %0d clocks, expected 509..513", n);
    end
    @(negedge clk);
    tests_run++;
    if (u_if.drv_state !== 3'd2) begin
      tests_failed++;
      $display("FAIL run_state: got %0d, expected 2", u_if.drv_state);
    end
    repeat (300) @(negedge clk);
    hi = 0;
    repeat (256) begin
      @(negedge clk);
      if (u_if.fan_pwm === 1'b1) hi++;
    end
    tests_run++;
    if (hi !== 255) begin
      tests_failed++;
      $display("FAIL fan_pwm_255: got %0d high, expected 255", hi);
    end
  endtask

  task automatic test_heat_cooldown();
    int n, hi;
    @(negedge clk) u_if.fan_heat = 8'd128;
    repeat (520) @(negedge clk);
    hi = 0;
    repeat (256) begin
      @(negedge clk);
      if (u_if.heat_pwm === 1'b1) hi++;
    end
    tests_run++;
    if (hi !== 128) begin
      tests_failed++;
      $display("FAIL heat_pwm_128: got %0d high, expected 128", hi);
    end
    u_if.fan_speed = 3'd0;
    repeat (258) @(negedge clk);
    tests_run++;
    if (u_if.drv_state !== 3'd3) begin
      tests_failed++;
      $display("FAIL cooldown_state: got %0d, expected 3", u_if.drv_state);
    end
    hi = 0;
    n  = 0;
    while (u_if.fan_duty !== 8'd64 && n < 1000) begin
      @(negedge clk);
      if (u_if.heat_pwm === 1'b1) hi++;
      n++;
    end
    tests_run++;
    if (hi !== 0 || n >= 1000) begin
      tests_failed++;
      $display("FAIL cooldown_to_64: got heat_hi=%0d clocks=%0d, expected 0 and <1000", hi, n);
    end
    n = 0;
    while (u_if.fan_duty === 8'd64 && n < 300) begin
      @(negedge clk);
      n++;
    end
    tests_run++;
    if (n < 64 || n > 67) begin
      tests_failed++;
      $display("FAIL runon_hold: got %0d clocks, expected 64..67", n);
    end
    n = 0;
    while (u_if.drv_state !== 3'd0 && n < 400) begin
      @(negedge clk);
      n++;
    end
    tests_run++;
    if (n < 120 || n > 136 || u_if.fan_duty !== 8'd0) begin
      tests_failed++;
      $display("FAIL cooldown_idle: got %0d clocks duty=%0d, expected 120..136 and 0", n, u_if.fan_duty);
    end
    u_if.fan_heat = 8'd0;
  endtask

  task automatic test_low_speed_no_heat();
    int n, hi;
    @(negedge clk);
    u_if.fan_speed = 3'd1;
    u_if.fan_heat  = 8'd200;
    hi = 0;
    repeat (1000) begin
      @(negedge clk);
      if (u_if.heat_pwm === 1'b1) hi++;
    end
    tests_run++;
    if (hi !== 0) begin
      tests_failed++;
      $display("FAIL low_speed_heat: got %0d high, expected 0", hi);
    end
    tests_run++;
    if (u_if.drv_state !== 3'd2 || u_if.fan_duty !== 8'd36) begin
      tests_failed++;
      $display("FAIL low_speed_run: got state=%0d duty=%0d, expected 2 and 36", u_if.drv_state, u_if.fan_duty);
    end
    u_if.fan_speed = 3'd0;
    n = 0;
    while (u_if.drv_state !== 3'd0 && n < 400) begin
      @(negedge clk);
      n++;
    end
    tests_run++;
    if (n > 80) begin
      tests_failed++;
      $display("FAIL no_runon: got %0d clocks to idle, expected <=80", n);
    end
    hi = 0;
    repeat (300) begin
      @(negedge clk);
      if (u_if.heat_pwm === 1'b1) hi++;
    end
    tests_run++;
    if (hi !== 0) begin
      tests_failed++;
      $display("FAIL idle_heat: got %0d high, expected 0", hi);
    end
    u_if.fan_heat = 8'd0;
  endtask

  task automatic test_stall();
    int n, hi;
    @(negedge clk) u_if.fan_speed = 3'd4;
    repeat (400) @(negedge clk);
    tests_run++;
    if (u_if.drv_state !== 3'd2 || u_if.fan_duty !== 8'd146) begin
      tests_failed++;
      $display("FAIL speed4_run: got state=%0d duty=%0d, expected 2 and 146", u_if.drv_state, u_if.fan_duty);
    end
    tach_en = 1'b0;
    n = 0;
    while (u_if.drv_state !== 3'd4 && n < 800) begin
      @(negedge clk);
      n++;
    end
    tests_run++;
    if (n > 610 || u_if.fault !== 1'b1 || u_if.fan_pwm !== 1'b0 || u_if.fan_duty !== 8'd0) begin
      tests_failed++;
      $display("FAIL stall_fault: got clocks=%0d fault=%0d pwm=%0d duty=%0d, expected <=610 1 0 0",
               n, u_if.fault, u_if.fan_pwm, u_if.fan_duty);
    end
    hi = 0;
    repeat (300) begin
      @(negedge clk);
      if (u_if.fan_pwm === 1'b1 || u_if.drv_state !== 3'd4) hi++;
    end
    tests_run++;
    if (hi !== 0) begin
      tests_failed++;
      $display("FAIL fault_hold: got %0d bad cycles, expected 0", hi);
    end
    u_if.fan_speed = 3'd0;
    @(negedge clk);
    tests_run++;
    if (u_if.drv_state !== 3'd0 || u_if.fault !== 1'b0) begin
      tests_failed++;
      $display("FAIL fault_clear: got state=%0d fault=%0d, expected 0 0", u_if.drv_state, u_if.fault);
    end
    tach_en = 1'b1;
  endtask

  task automatic test_reset_midramp();
    int n;
    @(negedge clk) u_if.fan_speed = 3'd7;
    n = 0;
    while (u_if.fan_duty !== 8'd100 && n < 400) begin
      @(negedge clk);
      n++;
    end
    #2 reset = 1'b0;
    #1;
    tests_run++;
    if ({u_if.fan_pwm, u_if.heat_pwm, u_if.fan_duty, u_if.drv_state, u_if.fault} !== 14'd0 || n >= 400) begin
      tests_failed++;
      $display("FAIL midramp_reset: got %0h (wait %0d), expected 0",
               {u_if.fan_pwm, u_if.heat_pwm, u_if.fan_duty, u_if.drv_state, u_if.fault}, n);
    end
    u_if.fan_speed = 3'd0;
    @(negedge clk) reset = 1'b1;
    repeat (5) @(negedge clk);
    tests_run++;
    if (u_if.drv_state !== 3'd0 || u_if.fan_duty !== 8'd0) begin
      tests_failed++;
      $display("FAIL restart_idle: got state=%0d duty=%0d, expected 0 0", u_if.drv_state, u_if.fan_duty);
    end
    u_if.fan_speed = 3'd7;
    repeat (20) @(negedge clk);
    tests_run++;
    if (u_if.drv_state !== 3'd1 || u_if.fan_duty < 8'd5 || u_if.fan_duty > 8'd11) begin
      tests_failed++;
      $display("FAIL restart_ramp: got state=%0d duty=%0d, expected 1 and 5..11", u_if.drv_state, u_if.fan_duty);
    end
    u_if.fan_speed = 3'd0;
  endtask

  initial begin
    test_reset();
    test_spinup();
    test_heat_cooldown();
    test_low_speed_no_heat();
    test_stall();
    test_reset_midramp();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/fan_driver.md
Name: fan_driver

Overview:
Actuator-side block that consumes the fan_speed/fan_heat commands produced by AC_control and turns them into PWM drive for the fan motor and the heater element. It ramps the fan duty smoothly and holds the heater off unless the fan is moving air. It also runs the fan on after heating to purge heat, and detects a stalled fan from its tachometer. It sits between AC_control and the board-level motor/heater drivers.

Parameters:
RAMP_DIV, 16, clocks per 1-LSB step of fan duty ramp (>=1)
HEAT_MIN_DUTY, 8'd64, minimum applied fan duty for heater enable
COOL_CYCLES, 1024, run-on cycles at HEAT_MIN_DUTY after heating
STALL_CYCLES, 4096, max clocks between tach rising edges before fault
STALL_MIN_DUTY, 8'd32, stall check active only when applied duty >= this

Ports:
clk  in  1  system clock
reset  in  1  asynchronous active-low reset
fan_speed  in  3  commanded fan speed, 0 = off, 7 = max
fan_heat  in  8  commanded heater duty, 0..255
fan_tach  in  1  asynchronous tach pulse from fan
fan_pwm  out  1  fan motor PWM
heat_pwm  out  1  heater PWM
fan_duty  out  8  current ramped fan duty
drv_state  out  3  FSM state encoding
fault  out  1  stall fault flag

Behaviour:
- Reset (reset=0, async): all outputs 0, state IDLE, PWM counter 0, duty 0, all timers 0.
- Target duty = {fan_speed, fan_speed, fan_speed[2:1]}:
  - 0 -> 0, 1 -> 36, 4 -> 146, 7 -> 255.
- Ramp: a prescaler counts RAMP_DIV clocks. On each tick, fan_duty moves 1 LSB toward its goal. It never overshoots and never wraps.
- PWM:
  - Free-running 8-bit counter, 256-clock period.
  - Applied fan and heat duties are latched when counter = 255.
  - fan_pwm = (cnt < applied_fan_duty), registered, so 1-clock latency.
  - Duty 0 gives constant 0. Duty 255 gives 255/256 high.
  - heat_pwm uses the same rule with applied_heat_duty.
- FSM states: IDLE=0, SPINUP=1, RUN=2, COOLDOWN=3, FAULT=4.
  - IDLE: goal 0, heat 0. fan_speed != 0 -> SPINUP.
  - SPINUP: goal = target, heat 0.
    - fan_duty == target -> RUN.
    - fan_speed == 0 -> COOLDOWN.
  - RUN: goal = target, tracks changes via ramp.
    - Heat duty = fan_heat when fan_duty >= HEAT_MIN_DUTY, else 0.
    - fan_speed == 0 -> COOLDOWN, and heat_was_on := (heat duty != 0 at exit).
  - COOLDOWN: heat duty forced 0 on the entry cycle.
    - If heat_was_on, goal = HEAT_MIN_DUTY for COOL_CYCLES clocks, then goal 0.
    - fan_duty == 0 after run-on -> IDLE.
    - fan_speed != 0 -> SPINUP; the run-on timer is cleared.
  - FAULT: fan_duty, applied duties and outputs forced 0 immediately; fault = 1.
    - Exit to IDLE only when fan_speed == 0 is sampled. fault then clears.
- Stall detection:
  - fan_tach passes through a 2-FF synchronizer, then rising-edge detect.
  - The timer runs in SPINUP/RUN/COOLDOWN while applied duty >= STALL_MIN_DUTY.
  - It clears on a tach edge or whenever the check is inactive.
  - Timer == STALL_CYCLES -> FAULT.
- Simultaneous events: fault has priority over all transitions, then fan_speed==0, then duty-reached.
- Reset mid-operation: instant return to all-zero outputs; no run-on.
- fan_heat != 0 with fan_speed == 0 never drives heat_pwm.

Decomposition:
- Package fan_driver_pkg: state enum (3-bit), the target-duty expansion function, PWM width constant 8.
- One sub-module, pwm_gen:
  - 8-bit counter, duty latch at wrap, registered compare.
  - Instantiated twice (fan, heat) with a shared counter enable.
- FSM, ramp, run-on and stall timers live in the top level.

Test Plan:
Bench parameters: RAMP_DIV=2, COOL_CYCLES=64, STALL_CYCLES=600; tach toggles every 200 clocks unless stated.
- Reset low then high, fan_speed=0 -> all outputs 0, drv_state=0 for 1000 clocks.
- fan_speed=7 -> drv_state=1, fan_duty reaches 255 after 510 clocks, then drv_state=2; fan_pwm high 255 of 256 clocks.
- In RUN at speed 7, fan_heat=128 -> heat_pwm high 128 of 256 clocks. Then fan_speed=0 -> heat_pwm 0 within 1 PWM period, fan_duty ramps to 64, holds 64 clocks, ramps to 0, drv_state=0.
- fan_speed=1 (duty 36 < 64) with fan_heat=200 -> heat_pwm stays 0 throughout.
- At speed 4, stop tach toggling -> after 600 clocks drv_state=4, fault=1, fan_pwm=0. fan_speed=0 -> drv_state=0, fault=0.
- Assert reset mid-ramp at fan_duty=100 -> all outputs 0 asynchronously; on release, restart from IDLE.
